calc_queue: RTL and testbench

//   Circular operand queue of 8-bit values for the queue calculator, downstream of the ALU stage.
//   - Consumes the ALU's queue_op / result / has_calc_err every clock.
//   - Presents the two oldest entries back to the ALU as operands.
//   - Tracks fill level and latches errors into a sticky HALT state until cleared.

---
 rtl/calc_queue_pkg.sv | 34 +++
 rtl/calc_queue_if.sv | 38 +++
 rtl/calc_queue_mem.sv | 26 ++
 rtl/calc_queue.sv | 128 ++++++++++++
 tb/tb_calc_queue.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/calc_queue_pkg.sv
// Shared definitions for the queue calculator: queue operation codes, error codes,
// FSM state encodings and the queue geometry.
package calc_queue_pkg;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    Q_PUSH         = 2'b00,
    Q_SLEEP        = 2'b01,
    Q_GET_AND_PUSH = 2'b10,
    Q_POP          = 2'b11
  } queue_op_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'b00,
    ERR_UNDERFLOW = 2'b01,
    ERR_OVERFLOW  = 2'b10,
    ERR_CALC      = 2'b11
  } err_code_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // Advance a pointer by n slots; the pointer width makes the wrap implicit.
  function automatic logic [ADDR_W-1:0] ptr_add(input logic [ADDR_W-1:0] ptr,
                                                input logic [1:0]        n);
    return ptr + ADDR_W'(n);
  endfunction

endpackage

// File: rtl/calc_queue_if.sv
// ALU <-> operand queue bus. The ALU side is the master; the queue is the slave.
// Optional peak_count signal exists only when CALC_QUEUE_PEAK_EN is defined.
interface calc_queue_if;
  import calc_queue_pkg::*;

  // Handshake: there is none; the queue consumes queue_op/result/has_calc_err
  // on every rising clock edge, and all outputs are valid continuously.
  logic [1:0]          queue_op;
  logic [DATA_W-1:0]   result;
  logic                has_calc_err;
  logic                err_clr;
  logic [2*DATA_W-1:0] operands;
  logic [ADDR_W:0]     count;
  logic                empty;
  logic                full;
  logic                halted;
  logic [1:0]          err_code;
`ifdef CALC_QUEUE_PEAK_EN
  logic [ADDR_W:0]     peak_count;
`endif

  modport master (
    output queue_op, result, has_calc_err, err_clr,
    input  operands, count, empty, full, halted, err_code
`ifdef CALC_QUEUE_PEAK_EN
    , input peak_count
`endif
  );

  modport slave (
    input  queue_op, result, has_calc_err, err_clr,
    output operands, count, empty, full, halted, err_code
`ifdef CALC_QUEUE_PEAK_EN
    , output peak_count
`endif
  );

endinterface

// File: rtl/calc_queue_mem.sv
// Queue storage: DEPTH x DATA_W register file, one synchronous write port and two
// asynchronous read ports. Contents are intentionally not reset.
module calc_queue_mem
  import calc_queue_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr0,
  input  logic [ADDR_W-1:0] i_raddr1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Reads see the pre-edge contents even when the same slot is being written.
   assign o_rdata0 = r_mem[i_raddr0];
   assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/calc_queue.sv
// Circular operand queue for the queue calculator: pointers, fill count, RUN/HALT FSM
// with sticky error codes. Define CALC_QUEUE_PEAK_EN to add a high-water-mark output.
module calc_queue
  import calc_queue_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  calc_queue_if.slave  bus
);

   logic [ADDR_W-1:0] r_head, r_tail;
   logic [ADDR_W:0]   r_count;
   state_e            r_state;
   err_code_e         r_err_code;

   logic [ADDR_W-1:0] w_head_next, w_tail_next, w_head_p1;
   logic [ADDR_W:0]   w_count_next;
   state_e            w_state_next;
   err_code_e         w_err_next;
   logic              w_we;
   logic              w_full;
   queue_op_e         w_op;
   logic [DATA_W-1:0] w_rd0, w_rd1;

   assign w_op      = queue_op_e'(bus.queue_op);
   assign w_full    = (r_count == (ADDR_W+1)'(DEPTH));
   assign w_head_p1 = ptr_add(r_head, 2'd1);

   always_comb begin
      w_head_next  = r_head;
      w_tail_next  = r_tail;
      w_count_next = r_count;
      w_state_next = r_state;
      w_err_next   = r_err_code;
      w_we         = 1'b0;
      case (r_state)
         ST_RUN: begin
            // Error priority: underflow, then overflow, then ALU calc error.
            if ((w_op == Q_POP && r_count == '0) ||
                (w_op == Q_GET_AND_PUSH && r_count < (ADDR_W+1)'(2))) begin
               w_err_next   = ERR_UNDERFLOW;
               w_state_next = ST_HALT;
            end else if (w_op == Q_PUSH && w_full) begin
               w_err_next   = ERR_OVERFLOW;
               w_state_next = ST_HALT;
            end else if (bus.has_calc_err) begin
               w_err_next   = ERR_CALC;
               w_state_next = ST_HALT;
            end else begin
               case (w_op)
                  Q_PUSH: begin
                     w_we         = 1'b1;
                     w_tail_next  = ptr_add(r_tail, 2'd1);
                     w_count_next = r_count + 1'b1;
                  end
                  Q_POP: begin
                     w_head_next  = ptr_add(r_head, 2'd1);
                     w_count_next = r_count - 1'b1;
                  end
                  Q_GET_AND_PUSH: begin
                     w_we         = 1'b1;
                     w_head_next  = ptr_add(r_head, 2'd2);
                     w_tail_next  = ptr_add(r_tail, 2'd1);
                     w_count_next = r_count - 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         ST_HALT: begin
            if (bus.err_clr) begin
               w_state_next = ST_RUN;
               w_err_next   = ERR_NONE;
            end
         end
         default: w_state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_state    <= ST_RUN;
         r_err_code <= ERR_NONE;
      end else begin
         r_head     <= w_head_next;
         r_tail     <= w_tail_next;
         r_count    <= w_count_next;
         r_state    <= w_state_next;
         r_err_code <= w_err_next;
      end
   end

   calc_queue_mem u_mem (
      .clk      (clk),
      .i_we     (w_we),
      .i_waddr  (r_tail),
      .i_wdata  (bus.result),
      .i_raddr0 (r_head),
      .i_raddr1 (w_head_p1),
      .o_rdata0 (w_rd0),
      .o_rdata1 (w_rd1)
   );

   assign bus.operands[DATA_W-1:0]        = (r_count >= (ADDR_W+1)'(1)) ? w_rd0 : '0;
   assign bus.operands[2*DATA_W-1:DATA_W] = (r_count >= (ADDR_W+1)'(2)) ? w_rd1 : '0;
   assign bus.count    = r_count;
   assign bus.empty    = (r_count == '0);
   assign bus.full     = w_full;
   assign bus.halted   = (r_state == ST_HALT);
   assign bus.err_code = r_err_code;

`ifdef CALC_QUEUE_PEAK_EN
   logic [ADDR_W:0] r_peak;

   // err_clr restarts the mark from zero; it rebuilds from the next count afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                         r_peak <= '0;
      else if (bus.err_clr)            r_peak <= '0;
      else if (w_count_next > r_peak)  r_peak <= w_count_next;
   end

   assign bus.peak_count = r_peak;
`endif

endmodule

// File: tb/tb_calc_queue.sv
// Directed self-checking bench for calc_queue with hand-computed expectations.
module tb_calc_queue;

   localparam logic [1:0] OP_PUSH  = 2'b00;
   localparam logic [1:0] OP_SLEEP = 2'b01;
   localparam logic [1:0] OP_GAP   = 2'b10;
   localparam logic [1:0] OP_POP   = 2'b11;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   calc_queue_if bus_if();

   calc_queue u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Apply one op for exactly one rising edge, then settle 1 time unit past it.
   task automatic step(input logic [1:0] op, input logic [7:0] res,
                       input logic cerr, input logic clr);
      @(negedge clk);
      bus_if.queue_op     = op;
      bus_if.result       = res;
      bus_if.has_calc_err = cerr;
      bus_if.err_clr      = clr;
      @(posedge clk);
      #1;
      @(negedge clk);
      bus_if.queue_op     = OP_SLEEP;
      bus_if.has_calc_err = 1'b0;
      bus_if.err_clr      = 1'b0;
   endtask

   task automatic check_status(input string tag, input int cnt, input logic [15:0] ops,
                               input logic hlt, input logic [1:0] ec);
      check({tag, "_count"},    32'(bus_if.count),    32'(cnt));
      check({tag, "_operands"}, 32'(bus_if.operands), 32'(ops));
      check({tag, "_halted"},   32'(bus_if.halted),   32'(hlt));
      check({tag, "_err_code"}, 32'(bus_if.err_code), 32'(ec));
   endtask

   initial begin
      bus_if.queue_op     = OP_SLEEP;
      bus_if.result       = 8'h00;
      bus_if.has_calc_err = 1'b0;
      bus_if.err_clr      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_status("reset", 0, 16'h0000, 1'b0, 2'b00);
      check("reset_empty", 32'(bus_if.empty), 32'd1);
      check("reset_full",  32'(bus_if.full),  32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Basic push and get-and-push
      step(OP_PUSH, 8'd5, 1'b0, 1'b0);
      check_status("push5", 1, 16'h0005, 1'b0, 2'b00);
      step(OP_PUSH, 8'd3, 1'b0, 1'b0);
      check_status("push3", 2, 16'h0305, 1'b0, 2'b00);
      check("push3_empty", 32'(bus_if.empty), 32'd0);
      step(OP_GAP, 8'd8, 1'b0, 1'b0);
      check_status("gap8", 1, 16'h0008, 1'b0, 2'b00);
      step(OP_GAP, 8'd1, 1'b0, 1'b0);
      check_status("gap_underflow", 1, 16'h0008, 1'b1, 2'b01);
      step(OP_SLEEP, 8'd0, 1'b0, 1'b1);
      check_status("gap_uf_clr", 1, 16'h0008, 1'b0, 2'b00);
      step(OP_POP, 8'd0, 1'b0, 1'b0);
      check_status("pop8", 0, 16'h0000, 1'b0, 2'b00);

      // Fill to DEPTH, then overflow
      for (int i = 1; i <= 16; i++) step(OP_PUSH, 8'(i), 1'b0, 1'b0);
      check_status("fill", 16, 16'h0201, 1'b0, 2'b00);
      check("fill_full", 32'(bus_if.full), 32'd1);
      step(OP_PUSH, 8'd99, 1'b0, 1'b0);
      check_status("overflow", 16, 16'h0201, 1'b1, 2'b10);
      step(OP_SLEEP, 8'd0, 1'b0, 1'b1);
      check_status("overflow_clr", 16, 16'h0201, 1'b0, 2'b00);
      for (int i = 1; i <= 16; i++) begin
         check($sformatf("drain_head%0d", i), 32'(bus_if.operands[7:0]), 32'(i));
         step(OP_POP, 8'd0, 1'b0, 1'b0);
      end
      check("drain_empty", 32'(bus_if.empty), 32'd1);

      // Underflow on empty POP outranks a simultaneous calc error
      step(OP_POP, 8'd0, 1'b1, 1'b0);
      check_status("pop_empty", 0, 16'h0000, 1'b1, 2'b01);
      step(OP_PUSH, 8'd42, 1'b0, 1'b0);
      check_status("halt_push_ignored", 0, 16'h0000, 1'b1, 2'b01);
      step(OP_PUSH, 8'd42, 1'b0, 1'b1);
      check_status("halt_clr_op_ignored", 0, 16'h0000, 1'b0, 2'b00);
      step(OP_SLEEP, 8'd0, 1'b0, 1'b1);
      check_status("clr_in_run", 0, 16'h0000, 1'b0, 2'b00);

      // Wrap: head=tail=3 here; 28 pairs bring tail to slot 15
      for (int i = 0; i < 28; i++) begin
         step(OP_PUSH, 8'(i + 100), 1'b0, 1'b0);
         if (i % 7 == 0)
            check($sformatf("pair_head%0d", i), 32'(bus_if.operands), 32'(i + 100));
         step(OP_POP, 8'd0, 1'b0, 1'b0);
      end
      step(OP_PUSH, 8'd7, 1'b0, 1'b0);
      step(OP_PUSH, 8'd9, 1'b0, 1'b0);
      check_status("wrap", 2, 16'h0907, 1'b0, 2'b00);
      step(OP_GAP, 8'h10, 1'b0, 1'b0);
      check_status("wrap_gap", 1, 16'h0010, 1'b0, 2'b00);
      step(OP_PUSH, 8'h20, 1'b0, 1'b0);
      check_status("push20", 2, 16'h2010, 1'b0, 2'b00);

      // Calc error with GET_AND_PUSH, count=2
      step(OP_GAP, 8'h55, 1'b1, 1'b0);
      check_status("calc_err", 2, 16'h2010, 1'b1, 2'b11);

      // Async reset between edges takes effect immediately
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_status("async_rst", 0, 16'h0000, 1'b0, 2'b00);
      check("async_rst_empty", 32'(bus_if.empty), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      step(OP_PUSH, 8'hA5, 1'b0, 1'b0);
      check_status("post_rst_push", 1, 16'h00A5, 1'b0, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
